// File: rtl/knight_pkg.sv
// Shared types for the Knight command path.
// FSM states and command opcodes.
package knight_pkg;

  localparam int CMD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [3:0] OP_CAL     = 4'h0;
  localparam logic [3:0] OP_MOVE    = 4'h2;
  localparam logic [3:0] OP_FANFARE = 4'h3;

endpackage

// File: rtl/cmd_fifo.sv
// Circular command buffer for move_queue.
// Count tracked separately; flush wins over push/pop.
import knight_pkg::*;

module cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [CMD_W-1:0]       wdata,
  output logic [CMD_W-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

  // storage write; contents are don't-care once flushed
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + CW'(1);
      else if (do_pop && !do_push)
        count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/move_queue.sv
// Queues Knight commands and issues them one at a time.
// Watchdog flushes the queue on a move that never finishes.
import knight_pkg::*;

module move_queue #(
  parameter int          DEPTH        = 4,
  parameter int unsigned TIMEOUT      = 24'd10_000_000,
  parameter bit          DROP_ON_FULL = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CMD_W-1:0]       in_cmd,
  input  logic                   in_vld,
  output logic                   clr_in,
  output logic [CMD_W-1:0]       cmd,
  output logic                   cmd_rdy,
  input  logic                   clr_cmd_rdy,
  input  logic                   done,
  input  logic                   abort,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   busy,
  output logic                   timeout_err,
  output logic                   ovf_err
);

  localparam int WW = $clog2(TIMEOUT + 1);

  state_t           state;
  state_t           state_d;
  logic [WW-1:0]    wd;
  logic [CMD_W-1:0] head;
  logic             take;
  logic             push;
  logic             pop;
  logic             flush;
  logic             drop;
  logic             wd_hit;

  // a new UART command is only looked at once the last clear has landed
  assign take   = in_vld & ~clr_in;
  assign push   = take & ~full & ~abort;
  assign drop   = take & full & DROP_ON_FULL & ~abort;
  assign pop    = (state == IDLE) & ~empty & ~abort;
  assign wd_hit = (state == WAIT) & ~done
                & (wd == WW'(TIMEOUT - 1));
  assign flush  = abort | wd_hit;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (in_cmd),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // next-state logic; abort overrides everything
  always_comb begin
    state_d = state;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (!empty) state_d = ISSUE;
        ISSUE:   if (clr_cmd_rdy) state_d = WAIT;
        WAIT:    if (done || wd_hit) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // state-decoded outputs
  always_comb begin
    cmd_rdy = (state == ISSUE);
    busy    = (state != IDLE);
  end

  // issued command register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cmd <= '0;
    else if (pop) cmd <= head;
  end

  // saturating watchdog, restarted by the issue acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wd <= '0;
    else if (state == ISSUE && clr_cmd_rdy)
      wd <= '0;
    else if (state == WAIT && wd != WW'(TIMEOUT))
      wd <= wd + WW'(1);
  end

  // clear pulse back to the UART side
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clr_in <= 1'b0;
    else        clr_in <= take & (~full | DROP_ON_FULL | abort);
  end

  // sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
      ovf_err     <= 1'b0;
    end else if (abort) begin
      timeout_err <= 1'b0;
      ovf_err     <= 1'b0;
    end else begin
      if (wd_hit) timeout_err <= 1'b1;
      if (drop)   ovf_err     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_move_queue.sv
// Directed bench for move_queue.
// Two instances: backpressure and drop-on-full.
module tb_move_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_cmd = 16'h0;
  logic        in_vld = 1'b0;
  logic        clr_cmd_rdy = 1'b0;
  logic        done = 1'b0;
  logic        abort = 1'b0;

  logic        clr_in, cmd_rdy, full, empty, busy;
  logic        timeout_err, ovf_err;
  logic [15:0] cmd;
  logic [2:0]  count;

  logic        clr_in_d, cmd_rdy_d, full_d, empty_d, busy_d;
  logic        timeout_err_d, ovf_err_d;
  logic [15:0] cmd_d;
  logic [2:0]  count_d;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  move_queue #(
    .DEPTH(4), .TIMEOUT(100), .DROP_ON_FULL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_cmd(in_cmd), .in_vld(in_vld), .clr_in(clr_in),
    .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .done(done), .abort(abort),
    .count(count), .full(full), .empty(empty), .busy(busy),
    .timeout_err(timeout_err), .ovf_err(ovf_err)
  );

  move_queue #(
    .DEPTH(4), .TIMEOUT(100), .DROP_ON_FULL(1'b1)
  ) dut_d (
    .clk(clk), .rst_n(rst_n),
    .in_cmd(in_cmd), .in_vld(in_vld), .clr_in(clr_in_d),
    .cmd(cmd_d), .cmd_rdy(cmd_rdy_d),
    .clr_cmd_rdy(clr_cmd_rdy), .done(done), .abort(abort),
    .count(count_d), .full(full_d), .empty(empty_d),
    .busy(busy_d),
    .timeout_err(timeout_err_d), .ovf_err(ovf_err_d)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_vld = 1'b0;
    clr_cmd_rdy = 1'b0;
    done = 1'b0;
    abort = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // UART side: hold in_vld until the clear pulse comes back
  task automatic send(input logic [15:0] c);
    bit got;
    got = 1'b0;
    in_cmd = c;
    in_vld = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      step();
      if (clr_in) got = 1'b1;
    end
    in_vld = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL send_%h: clr_in never seen", c);
    end
  endtask

  // cmd_proc side: wait, check, ack, done
  task automatic service(input logic [15:0] exp);
    for (int i = 0; i < 20 && !cmd_rdy; i++) step();
    checks++;
    if (cmd_rdy !== 1'b1) begin
      failures++;
      $display("FAIL svc_rdy_%h: cmd_rdy=%b want 1", exp, cmd_rdy);
    end
    checks++;
    if (cmd !== exp) begin
      failures++;
      $display("FAIL svc_cmd: cmd=%h want %h", cmd, exp);
    end
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
    checks++;
    if ({cmd_rdy, busy} !== 2'b01) begin
      failures++;
      $display("FAIL svc_ack_%h: rdy,busy=%b want 01",
               exp, {cmd_rdy, busy});
    end
    step();
    checks++;
    if (cmd_rdy !== 1'b0) begin
      failures++;
      $display("FAIL svc_wait_%h: cmd_rdy=%b want 0", exp, cmd_rdy);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    checks++;
    if ({cmd_rdy, busy} !== 2'b00) begin
      failures++;
      $display("FAIL svc_idle_%h: rdy,busy=%b want 00",
               exp, {cmd_rdy, busy});
    end
  endtask

  task automatic test_reset();
    logic [25:0] got;
    step();
    got = {cmd, cmd_rdy, clr_in, count, empty, full,
           busy, timeout_err, ovf_err};
    checks++;
    if (got !== {16'h0, 2'b00, 3'd0, 1'b1, 4'b0000}) begin
      failures++;
      $display("FAIL reset: got %h want %h", got,
               {16'h0, 2'b00, 3'd0, 1'b1, 4'b0000});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    do_reset();
    in_cmd = 16'h3BF1;
    in_vld = 1'b1;
    step();
    in_vld = 1'b0;
    checks++;
    if ({clr_in, count, cmd_rdy} !== {1'b1, 3'd1, 1'b0}) begin
      failures++;
      $display("FAIL single_c1: clr,count,rdy=%b want 10010",
               {clr_in, count, cmd_rdy});
    end
    step();
    checks++;
    if ({cmd_rdy, cmd, count} !== {1'b1, 16'h3BF1, 3'd0}) begin
      failures++;
      $display("FAIL single_c2: rdy=%b cmd=%h count=%0d",
               cmd_rdy, cmd, count);
    end
    service(16'h3BF1);
    checks++;
    if ({empty, busy} !== 2'b10) begin
      failures++;
      $display("FAIL single_end: empty,busy=%b want 10",
               {empty, busy});
    end
  endtask

  task automatic fill_five();
    send(16'h0001);
    send(16'h3BF1);
    send(16'h2002);
    send(16'h33F2);
    send(16'h37F2);
  endtask

  task automatic test_back_to_back();
    do_reset();
    fill_five();
    checks++;
    if ({full, count, cmd_rdy, cmd} !==
        {1'b1, 3'd4, 1'b1, 16'h0001}) begin
      failures++;
      $display("FAIL b2b_full: full=%b count=%0d rdy=%b cmd=%h",
               full, count, cmd_rdy, cmd);
    end
    service(16'h0001);
    step();
    checks++;
    if ({cmd_rdy, cmd} !== {1'b1, 16'h3BF1}) begin
      failures++;
      $display("FAIL b2b_n2: rdy=%b cmd=%h want 1 3bf1",
               cmd_rdy, cmd);
    end
    service(16'h3BF1);
    service(16'h2002);
    service(16'h33F2);
    service(16'h37F2);
    step();
    checks++;
    if ({empty, busy, cmd_rdy} !== 3'b100) begin
      failures++;
      $display("FAIL b2b_end: empty,busy,rdy=%b want 100",
               {empty, busy, cmd_rdy});
    end
  endtask

  task automatic test_full_policy();
    do_reset();
    fill_five();
    step();
    in_cmd = 16'h2ABC;
    in_vld = 1'b1;
    step();
    checks++;
    if ({clr_in_d, ovf_err_d, count_d} !== {2'b11, 3'd4}) begin
      failures++;
      $display("FAIL drop: clr=%b ovf=%b count=%0d want 1 1 4",
               clr_in_d, ovf_err_d, count_d);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({clr_in, ovf_err, count} !== {2'b00, 3'd4}) begin
        failures++;
        $display("FAIL bp_hold%0d: clr=%b ovf=%b count=%0d",
                 i, clr_in, ovf_err, count);
      end
      if (i < 2) step();
    end
    service(16'h0001);
    step();
    checks++;
    if ({clr_in, count} !== {1'b0, 3'd3}) begin
      failures++;
      $display("FAIL bp_pop: clr=%b count=%0d want 0 3",
               clr_in, count);
    end
    step();
    checks++;
    if ({clr_in, count} !== {1'b1, 3'd4}) begin
      failures++;
      $display("FAIL bp_accept: clr=%b count=%0d want 1 4",
               clr_in, count);
    end
    in_vld = 1'b0;
    service(16'h3BF1);
    service(16'h2002);
    service(16'h33F2);
    service(16'h37F2);
    service(16'h2ABC);
  endtask

  task automatic test_timeout();
    do_reset();
    send(16'h2002);
    send(16'h33F2);
    send(16'h37F2);
    for (int i = 0; i < 20 && !cmd_rdy; i++) step();
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
    repeat (99) step();
    checks++;
    if ({timeout_err, busy, count} !== {2'b01, 3'd2}) begin
      failures++;
      $display("FAIL to_c99: err=%b busy=%b count=%0d",
               timeout_err, busy, count);
    end
    step();
    checks++;
    if ({timeout_err, busy, count, empty} !==
        {2'b10, 3'd0, 1'b1}) begin
      failures++;
      $display("FAIL to_hit: err=%b busy=%b count=%0d empty=%b",
               timeout_err, busy, count, empty);
    end
    step();
    checks++;
    if ({busy, cmd_rdy, timeout_err} !== 3'b001) begin
      failures++;
      $display("FAIL to_after: busy,rdy,err=%b want 001",
               {busy, cmd_rdy, timeout_err});
    end
  endtask

  task automatic test_done_at_limit();
    do_reset();
    send(16'h33F2);
    for (int i = 0; i < 20 && !cmd_rdy; i++) step();
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
    repeat (99) step();
    done = 1'b1;
    step();
    done = 1'b0;
    checks++;
    if ({timeout_err, busy} !== 2'b00) begin
      failures++;
      $display("FAIL done_limit: err,busy=%b want 00",
               {timeout_err, busy});
    end
  endtask

  // runs straight after the timeout test so the error is set
  task automatic test_abort();
    send(16'h3BF1);
    send(16'h2002);
    send(16'h33F2);
    send(16'h37F2);
    for (int i = 0; i < 20 && !cmd_rdy; i++) step();
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
    checks++;
    if ({count, busy, timeout_err} !== {3'd3, 2'b11}) begin
      failures++;
      $display("FAIL ab_pre: count=%0d busy=%b err=%b",
               count, busy, timeout_err);
    end
    abort = 1'b1;
    in_cmd = 16'h0ABC;
    in_vld = 1'b1;
    step();
    abort = 1'b0;
    in_vld = 1'b0;
    checks++;
    if ({count, cmd_rdy, busy, timeout_err, ovf_err, clr_in}
        !== {3'd0, 5'b00001}) begin
      failures++;
      $display("FAIL ab_post: cnt=%0d rdy=%b busy=%b to=%b ov=%b clr=%b",
               count, cmd_rdy, busy, timeout_err, ovf_err, clr_in);
    end
    step();
    checks++;
    if ({count, busy, clr_in} !== {3'd0, 2'b00}) begin
      failures++;
      $display("FAIL ab_settle: count=%0d busy=%b clr=%b",
               count, busy, clr_in);
    end
  endtask

  task automatic test_async_reset();
    logic [25:0] got;
    do_reset();
    send(16'h3BF1);
    send(16'h2002);
    for (int i = 0; i < 20 && !cmd_rdy; i++) step();
    checks++;
    if ({cmd_rdy, count} !== {1'b1, 3'd1}) begin
      failures++;
      $display("FAIL ar_pre: rdy=%b count=%0d want 1 1",
               cmd_rdy, count);
    end
    #2 rst_n = 1'b0;
    #1;
    got = {cmd, cmd_rdy, clr_in, count, empty, full,
           busy, timeout_err, ovf_err};
    checks++;
    if (got !== {16'h0, 2'b00, 3'd0, 1'b1, 4'b0000}) begin
      failures++;
      $display("FAIL async_rst: got %h want %h", got,
               {16'h0, 2'b00, 3'd0, 1'b1, 4'b0000});
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if ({busy, cmd_rdy, count} !== {2'b00, 3'd0}) begin
      failures++;
      $display("FAIL ar_post: busy=%b rdy=%b count=%0d",
               busy, cmd_rdy, count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_policy();
    test_timeout();
    test_abort();
    test_done_at_limit();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
